// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, source IDs and echo byte transform
package uart_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT_BUSY = 2'd2, WAIT_IDLE = 2'd3} state_t;
  typedef enum logic {SRC_FIFO = 1'b0, SRC_MSG = 1'b1} src_t;
  function automatic logic [DATA_W-1:0] echo_xform(input logic [DATA_W-1:0] b);
    return b[DATA_W-1] ? ~b : b;
  endfunction
endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: echo, message, transmitter and status signals of the scheduler
interface uart_tx_scheduler_if #(parameter int DEPTH = 4);
  import uart_pkg::*;
  logic [DATA_W-1:0] rx_data;
  logic rx_status;
  logic msg_valid;
  logic [DATA_W-1:0] msg_data;
  logic msg_ready;
  logic tx_status;
  logic tx_en;
  logic [DATA_W-1:0] tx_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic overflow;
  logic ovf_clr;
  logic busy;
  modport master (output rx_data, rx_status, msg_valid, msg_data, tx_status, ovf_clr,
                  input msg_ready, tx_en, tx_data, fifo_count, overflow, busy);
  modport slave (input rx_data, rx_status, msg_valid, msg_data, tx_status, ovf_clr,
                 output msg_ready, tx_en, tx_data, fifo_count, overflow, busy);
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: byte FIFO that accepts a push at full when a pop happens on the same edge
module uart_byte_fifo
  import uart_pkg::*;
#(parameter int DEPTH = 4)
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_push,
  input  logic i_pop,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout,
  output logic o_full,
  output logic o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_pop, w_push;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  // storage needs no reset; pointers define what is valid
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr] <= i_din;
  // pointers wrap naturally at power-of-2 depth; occupancy tracks push/pop
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter between RX echo and a message source
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter bit INVERT_MSB = 1'b1,
  parameter int BUSY_TIMEOUT = 15
)
(
  input logic sysclk,
  input logic reset_n,
  uart_tx_scheduler_if.slave bus
);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1) + 1;
  state_t r_state, w_next;
  src_t r_last, w_sel;
  logic [DATA_W-1:0] r_tx_data, w_rx_byte, w_fifo_dout;
  logic [CW-1:0] r_cnt;
  logic r_ovf, w_full, w_empty, w_grant, w_pop, w_drop, w_cnt_done;
  assign w_rx_byte  = INVERT_MSB ? echo_xform(bus.rx_data) : bus.rx_data;
  assign w_sel      = (!w_empty && bus.msg_valid) ? src_t'(~r_last) : (bus.msg_valid ? SRC_MSG : SRC_FIFO);
  assign w_grant    = (r_state == IDLE) && bus.tx_status && (!w_empty || bus.msg_valid);
  assign w_pop      = w_grant && (w_sel == SRC_FIFO);
  assign w_drop     = bus.rx_status && w_full && !w_pop;
  assign w_cnt_done = (r_cnt + CW'(1)) == CW'(BUSY_TIMEOUT);
  assign bus.msg_ready = w_grant && (w_sel == SRC_MSG);
  assign bus.tx_en     = r_state == LAUNCH;
  assign bus.tx_data   = r_tx_data;
  assign bus.overflow  = r_ovf;
  assign bus.busy      = r_state != IDLE;
  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk(sysclk), .i_rst_n(reset_n), .i_push(bus.rx_status), .i_pop(w_pop),
    .i_din(w_rx_byte), .o_dout(w_fifo_dout), .o_full(w_full), .o_empty(w_empty),
    .o_count(bus.fifo_count)
  );
  // state, grant bookkeeping, busy timeout counter and sticky overflow
  always_ff @(posedge sysclk or negedge reset_n)
    if (!reset_n) begin
      r_state   <= IDLE;
      r_last    <= SRC_MSG;
      r_tx_data <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_last    <= w_sel;
        r_tx_data <= (w_sel == SRC_MSG) ? bus.msg_data : w_fifo_dout;
      end
      if (r_state == LAUNCH) r_cnt <= '0;
      else if (r_state == WAIT_BUSY && bus.tx_status) r_cnt <= r_cnt + 1'b1;
      if (w_drop) r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;
    end
  // next state; a transmitter that never reports busy is abandoned after the timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_grant) w_next = LAUNCH;
      LAUNCH:    w_next = WAIT_BUSY;
      WAIT_BUSY: if (!bus.tx_status || w_cnt_done) w_next = WAIT_IDLE;
      WAIT_IDLE: if (bus.tx_status) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench with a reactive transmitter model
module tb_uart_tx_scheduler;
  localparam int DEPTH = 4;
  localparam int BUSY_TIMEOUT = 15;
  logic sysclk = 1'b0;
  logic reset_n = 1'b0;
  uart_tx_scheduler_if #(.DEPTH(DEPTH)) bus ();
  uart_tx_scheduler_if #(.DEPTH(DEPTH)) bus2 ();
  uart_tx_scheduler #(.DEPTH(DEPTH), .INVERT_MSB(1'b1), .BUSY_TIMEOUT(BUSY_TIMEOUT))
    dut (.sysclk(sysclk), .reset_n(reset_n), .bus(bus));
  uart_tx_scheduler #(.DEPTH(DEPTH), .INVERT_MSB(1'b0), .BUSY_TIMEOUT(BUSY_TIMEOUT))
    dut2 (.sysclk(sysclk), .reset_n(reset_n), .bus(bus2));

  always #5 sysclk = ~sysclk;

  int total = 0, bad = 0;
  logic [7:0] exp_q[$];
  int cyc = 0, last_launch = -100, prev_launch = -100, n_launch = 0, n_ready = 0;
  int busy_cnt = 0, busy_len = 10;
  bit hold_low = 1'b0, no_drop = 1'b0;

  function automatic logic [7:0] model_xf(input logic [7:0] b);
    return (b >= 8'h80) ? 8'hFF - b : b;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // transmitter model: busy for busy_len cycles after each launch unless told to ignore it
  always @(negedge sysclk) begin
    if (bus.tx_en && !no_drop) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    bus.tx_status = !(hold_low || busy_cnt > 0);
  end

  // monitor: every launch must match the head of the expected queue and respect spacing
  always @(negedge sysclk) if (reset_n) begin
    cyc++;
    if (bus.msg_ready) n_ready++;
    if (bus.tx_en) begin
      n_launch++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_launch got=%0h want=none", bus.tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.tx_data !== e) begin
          bad++;
          $display("FAIL launch_data got=%0h want=%0h", bus.tx_data, e);
        end
      end
      chk("launch_spacing_ok", 32'(cyc - last_launch >= 3), 1);
      prev_launch = last_launch;
      last_launch = cyc;
    end
  end

  task automatic rx_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_status = 1'b1;
    @(posedge sysclk); #1;
    bus.rx_status = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || bus.busy) && k < 3000) begin
      @(posedge sysclk); #1;
      k++;
    end
    chk(name, exp_q.size(), 0);
    chk({name, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b5 [5];
    logic [7:0] r;
    int k, n0;
    bus.rx_data = '0; bus.rx_status = 0; bus.msg_valid = 0; bus.msg_data = '0; bus.ovf_clr = 0;
    bus2.rx_data = '0; bus2.rx_status = 0; bus2.msg_valid = 0; bus2.msg_data = '0; bus2.ovf_clr = 0;
    bus2.tx_status = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    chk("rst_tx_en", bus.tx_en, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_msg_ready", bus.msg_ready, 0);
    chk("rst_fifo_count", bus.fifo_count, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_busy", bus.busy, 0);
    reset_n = 1'b1;
    @(posedge sysclk); #1;

    // single echo byte and its launch latency
    exp_q.push_back(model_xf(8'h41));
    rx_byte(8'h41);
    chk("t1_count_after_push", bus.fifo_count, 1);
    chk("t1_no_early_launch", bus.tx_en, 0);
    @(posedge sysclk); #1;
    chk("t1_launch_latency", bus.tx_en, 1);
    chk("t1_tx_data", bus.tx_data, 8'h41);
    chk("t1_count_popped", bus.fifo_count, 0);
    @(posedge sysclk); #1;
    chk("t1_single_pulse", bus.tx_en, 0);
    wait_drain("t1_drain");

    // MSB inversion on and off
    exp_q.push_back(model_xf(8'hC3));
    rx_byte(8'hC3);
    wait_drain("t2_drain");
    chk("t2_inv1_data", bus.tx_data, 8'h3C);
    bus2.rx_data = 8'hC3; bus2.rx_status = 1'b1;
    @(posedge sysclk); #1;
    bus2.rx_status = 1'b0;
    k = 0;
    while (!bus2.tx_en && k < 10) begin @(posedge sysclk); #1; k++; end
    chk("t2_inv0_launch", bus2.tx_en, 1);
    chk("t2_inv0_data", bus2.tx_data, 8'hC3);

    // random echo traffic, never more pending than the FIFO can hold
    for (int i = 0; i < 40; i++) begin
      busy_len = $urandom_range(3, 12);
      if (exp_q.size() < DEPTH) begin
        r = 8'($urandom);
        exp_q.push_back(model_xf(r));
        rx_byte(r);
      end
      repeat ($urandom_range(0, 15)) @(posedge sysclk);
      #1;
    end
    wait_drain("rnd_echo_drain");

    // random message traffic through the valid/ready handshake
    for (int i = 0; i < 20; i++) begin
      busy_len = $urandom_range(3, 12);
      bus.msg_data = 8'($urandom);
      bus.msg_valid = 1'b1;
      k = 0;
      do begin @(negedge sysclk); k++; end while (!bus.msg_ready && k < 100);
      chk("rnd_msg_ready_seen", bus.msg_ready, 1);
      exp_q.push_back(bus.msg_data);
      @(posedge sysclk); #1;
      bus.msg_valid = 1'b0;
      repeat ($urandom_range(0, 6)) @(posedge sysclk);
      #1;
    end
    wait_drain("rnd_msg_drain");

    // round robin between queued echo bytes and a held message
    busy_len = 10;
    reset_n = 1'b0;
    @(posedge sysclk); #1;
    reset_n = 1'b1;
    hold_low = 1'b1;
    @(posedge sysclk); #1;
    rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'h03);
    chk("t3_count", bus.fifo_count, 3);
    exp_q.push_back(8'h01); exp_q.push_back(8'h55); exp_q.push_back(8'h02);
    exp_q.push_back(8'h55); exp_q.push_back(8'h03);
    bus.msg_data = 8'h55;
    bus.msg_valid = 1'b1;
    n_ready = 0;
    @(posedge sysclk); #1;
    chk("t3_no_ready_while_busy", n_ready, 0);
    hold_low = 1'b0;
    k = 0;
    while (n_ready < 2 && k < 500) begin @(posedge sysclk); #1; k++; end
    bus.msg_valid = 1'b0;
    wait_drain("t3_drain");
    chk("t3_ready_count", n_ready, 2);

    // overflow with a stalled transmitter
    hold_low = 1'b1;
    @(posedge sysclk); #1;
    b5 = '{8'h11, 8'h92, 8'h23, 8'hF4, 8'h35};
    for (int i = 0; i < 5; i++) begin
      if (i < DEPTH) exp_q.push_back(model_xf(b5[i]));
      rx_byte(b5[i]);
    end
    chk("t4_count_full", bus.fifo_count, DEPTH);
    chk("t4_overflow_set", bus.overflow, 1);
    bus.ovf_clr = 1'b1;
    rx_byte(8'h66);
    bus.ovf_clr = 1'b0;
    chk("t4_set_wins_over_clr", bus.overflow, 1);
    bus.ovf_clr = 1'b1;
    @(posedge sysclk); #1;
    bus.ovf_clr = 1'b0;
    chk("t4_overflow_cleared", bus.overflow, 0);
    chk("t4_count_still_full", bus.fifo_count, DEPTH);
    hold_low = 1'b0;
    wait_drain("t4_drain");

    // transmitter that never reports busy: timeout then next byte
    no_drop = 1'b1;
    exp_q.push_back(model_xf(8'h7A)); exp_q.push_back(model_xf(8'hB0));
    rx_byte(8'h7A); rx_byte(8'hB0);
    wait_drain("t5_drain");
    chk("t5_timeout_gap", 32'(last_launch - prev_launch), BUSY_TIMEOUT + 3);
    no_drop = 1'b0;

    // asynchronous reset in WAIT_IDLE with two bytes queued
    busy_len = 10;
    n0 = n_launch;
    exp_q.push_back(model_xf(8'h21));
    rx_byte(8'h21); rx_byte(8'h22); rx_byte(8'h23);
    k = 0;
    while (n_launch == n0 && k < 50) begin @(posedge sysclk); #1; k++; end
    repeat (2) @(posedge sysclk);
    #1;
    chk("t6_busy_before_reset", bus.busy, 1);
    chk("t6_count_before_reset", bus.fifo_count, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_tx_en", bus.tx_en, 0);
    chk("t6_rst_tx_data", bus.tx_data, 0);
    chk("t6_rst_count", bus.fifo_count, 0);
    chk("t6_rst_overflow", bus.overflow, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_msg_ready", bus.msg_ready, 0);
    @(posedge sysclk); #1;
    reset_n = 1'b1;
    n0 = n_launch;
    repeat (40) @(posedge sysclk);
    #1;
    chk("t6_no_launch_after_reset", n_launch - n0, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single UART transmitter between two sources: the RX echo path and a message requester (e.g. a status/banner generator). Echo bytes are captured into a small FIFO, with the MSB-set inversion transform applied at capture. A round-robin arbiter issues one-cycle tx_en launches only while the transmitter reports idle. It sits between the UART receiver/transmitter pair and replaces the direct RX→TX coupling.

Parameters:
DEPTH, 4, echo FIFO depth in bytes; power of 2, minimum 2
INVERT_MSB, 1, 1 = store ~rx_data when rx_data[7]==1; 0 = store rx_data unchanged
BUSY_TIMEOUT, 15, cycles to wait in WAIT_BUSY for tx_status to fall before giving up

Ports:
sysclk  in  1  system clock; all logic on its rising edge
reset_n  in  1  asynchronous, active-low reset
rx_data  in  8  received byte; valid while rx_status=1
rx_status  in  1  one-cycle pulse: byte received
msg_valid  in  1  message requester has a byte
msg_data  in  8  message byte; held stable while msg_valid=1
msg_ready  out  1  one-cycle accept strobe; the byte transfers when msg_valid & msg_ready
tx_status  in  1  1 = transmitter idle, 0 = sending
tx_en  out  1  one-cycle launch pulse to the transmitter
tx_data  out  8  byte to transmit; stable from launch until the next grant
fifo_count  out  $clog2(DEPTH)+1  current echo FIFO occupancy
overflow  out  1  sticky; echo byte dropped because the FIFO was full
ovf_clr  in  1  clears overflow synchronously
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset (async, reset_n=0): tx_en=0, tx_data=8'h00, msg_ready=0, fifo_count=0, overflow=0, busy=0, state=IDLE, last_grant=MSG (so the FIFO wins the first tie), timeout counter=0.
- Echo FIFO push: on any edge where rx_status=1. The transformed byte is written if the FIFO is not full, or if it is full and a pop occurs on the same edge (a simultaneous push and pop at full is accepted). Otherwise the byte is dropped and overflow is set.
- ovf_clr and a new drop on the same edge: overflow stays 1 (set wins).
- Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE.
- IDLE:
  - Waits for tx_status=1 and at least one pending source (FIFO non-empty, or msg_valid=1).
  - Selection: the only pending source; if both are pending, the source not equal to last_grant.
  - On the grant edge: tx_data is loaded, last_grant is updated, state goes to LAUNCH.
  - FIFO grant: the FIFO is popped on the grant edge.
  - MSG grant: msg_ready=1 during the IDLE cycle in which the grant is decided (combinational from state, tx_status, selection); the byte is captured on that edge.
- LAUNCH: tx_en=1 for exactly this cycle; the timeout counter is cleared; next state is WAIT_BUSY.
- WAIT_BUSY:
  - tx_status=0 → WAIT_IDLE.
  - Else the counter increments; at counter==BUSY_TIMEOUT, go to WAIT_IDLE anyway. The byte is considered lost and is not retried.
- WAIT_IDLE: tx_status=1 → IDLE.
- Outputs outside these rules: tx_en is never high outside LAUNCH; msg_ready is never high outside IDLE.
- Latency: rx_status sampled at edge E with the FIFO empty, FSM in IDLE and tx_status=1 → FIFO written at E, grant at E+1, tx_en high in the cycle after E+1.
- Throughput: at most one launch per full transmitter busy→idle cycle; a minimum of 3 cycles between tx_en pulses.
- Reset mid-operation: everything returns to reset values immediately; FIFO contents are discarded.
- fifo_count is a registered value and updates on the same edge as the push/pop.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding (IDLE=2'd0, LAUNCH=2'd1, WAIT_BUSY=2'd2, WAIT_IDLE=2'd3)
  - source IDs (SRC_FIFO=1'b0, SRC_MSG=1'b1)
  - the byte-transform function (MSB-set inversion), reused by any other echo path
- One sub-module: uart_byte_fifo (parameter DEPTH, 8-bit wide; push/pop/full/empty/count).
- The arbiter and FSM remain in uart_tx_scheduler.

Test Plan:
1. Reset, tx_status=1; rx_status pulse with rx_data=8'h41 → exactly one tx_en pulse 2 cycles later; tx_data=8'h41; fifo_count returns to 0.
2. rx_data=8'hC3 with INVERT_MSB=1 → tx_data=8'h3C; repeat with INVERT_MSB=0 → tx_data=8'hC3.
3. Hold msg_valid=1 with msg_data=8'h55 while feeding 3 echo bytes 8'h01, 8'h02, 8'h03 (transmitter model busy 10 cycles per byte) → launch order 01, 55, 02, 55, 03; msg_ready is high exactly on its grant cycles.
4. Hold tx_status=0; push 5 echo bytes → fifo_count=4, overflow=1, 5th byte never transmitted; ovf_clr pulse → overflow=0.
5. Transmitter model never drops tx_status after tx_en → FSM leaves WAIT_BUSY after BUSY_TIMEOUT=15 cycles; the next pending byte launches normally.
6. Assert reset_n=0 during WAIT_IDLE with 2 bytes queued → all outputs at reset values asynchronously; after release, no tx_en without new input.
